// File: rtl/ptw_axi_arbiter_pkg.sv
// Shared types for the page-table-walker AXI read arbiter.
// Walker-facing grant encoding is also used by the RR arbiter.
package ptw_axi_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } ptw_arb_state_e;

   localparam logic GNT_IMMU = 1'b0;
   localparam logic GNT_DMMU = 1'b1;

   localparam int unsigned AXI_LEN_W   = 8;
   localparam int unsigned AXI_SIZE_W  = 3;
   localparam int unsigned AXI_BURST_W = 2;
   localparam int unsigned AXI_RESP_W  = 2;

endpackage

// File: rtl/ptw_axi_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; purely combinational.
// Requester 0 maps to GNT_IMMU, requester 1 to GNT_DMMU.
module rr_arb2
   import ptw_axi_arbiter_pkg::*;
(
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_last_grant,
   output logic [1:0] o_gnt,
   output logic       o_gnt_idx
);

   logic w_idx;

   always_comb begin
      w_idx = GNT_IMMU;
      if (i_req0 && i_req1) begin
         w_idx = ~i_last_grant;
      end else if (i_req1) begin
         w_idx = GNT_DMMU;
      end
   end

   assign o_gnt_idx = w_idx;
   assign o_gnt[0]  = i_req0 && (w_idx == GNT_IMMU);
   assign o_gnt[1]  = i_req1 && (w_idx == GNT_DMMU);

endmodule

// File: rtl/ptw_axi_arbiter.sv
// Shares one downstream AXI read channel between the I- and D-side page-table walkers,
// one transaction at a time, with round-robin arbitration and grant-based R routing.
module ptw_axi_arbiter
   import ptw_axi_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_W   = 4
) (
   input  logic                   clk_i,
   input  logic                   arst_i,

   input  logic                   i_immu_arvalid,
   output logic                   o_immu_arready,
   input  logic [ADDR_W-1:0]      i_immu_araddr,
   input  logic [ID_W-1:0]        i_immu_arid,
   input  logic [AXI_LEN_W-1:0]   i_immu_arlen,
   input  logic [AXI_SIZE_W-1:0]  i_immu_arsize,
   input  logic [AXI_BURST_W-1:0] i_immu_arburst,
   output logic                   o_immu_rvalid,
   input  logic                   i_immu_rready,
   output logic [DATA_W-1:0]      o_immu_rdata,
   output logic [AXI_RESP_W-1:0]  o_immu_rresp,
   output logic                   o_immu_rlast,
   output logic [ID_W-1:0]        o_immu_rid,

   input  logic                   i_dmmu_arvalid,
   output logic                   o_dmmu_arready,
   input  logic [ADDR_W-1:0]      i_dmmu_araddr,
   input  logic [ID_W-1:0]        i_dmmu_arid,
   input  logic [AXI_LEN_W-1:0]   i_dmmu_arlen,
   input  logic [AXI_SIZE_W-1:0]  i_dmmu_arsize,
   input  logic [AXI_BURST_W-1:0] i_dmmu_arburst,
   output logic                   o_dmmu_rvalid,
   input  logic                   i_dmmu_rready,
   output logic [DATA_W-1:0]      o_dmmu_rdata,
   output logic [AXI_RESP_W-1:0]  o_dmmu_rresp,
   output logic                   o_dmmu_rlast,
   output logic [ID_W-1:0]        o_dmmu_rid,

   output logic                   o_mem_arvalid,
   input  logic                   i_mem_arready,
   output logic [ADDR_W-1:0]      o_mem_araddr,
   output logic [ID_W-1:0]        o_mem_arid,
   output logic [AXI_LEN_W-1:0]   o_mem_arlen,
   output logic [AXI_SIZE_W-1:0]  o_mem_arsize,
   output logic [AXI_BURST_W-1:0] o_mem_arburst,
   input  logic                   i_mem_rvalid,
   output logic                   o_mem_rready,
   input  logic [DATA_W-1:0]      i_mem_rdata,
   input  logic [AXI_RESP_W-1:0]  i_mem_rresp,
   input  logic                   i_mem_rlast,
   input  logic [ID_W-1:0]        i_mem_rid,

   output logic                   busy_o
);

   ptw_arb_state_e         r_state;
   logic                   r_grant;
   logic                   r_last_grant;
   logic                   r_mem_arvalid;
   logic                   r_busy;
   logic [ADDR_W-1:0]      r_araddr;
   logic [ID_W-1:0]        r_arid;
   logic [AXI_LEN_W-1:0]   r_arlen;
   logic [AXI_SIZE_W-1:0]  r_arsize;
   logic [AXI_BURST_W-1:0] r_arburst;

   logic [1:0]             w_gnt;
   logic                   w_gnt_idx;
   logic                   w_idle;
   logic                   w_in_data;
   logic                   w_rready;
   logic                   w_take;

   rr_arb2 u_rr_arb2 (
      .i_req0       (i_immu_arvalid),
      .i_req1       (i_dmmu_arvalid),
      .i_last_grant (r_last_grant),
      .o_gnt        (w_gnt),
      .o_gnt_idx    (w_gnt_idx)
   );

   assign w_idle    = (r_state == IDLE) && !arst_i;
   assign w_in_data = (r_state == DATA) && !arst_i;
   assign w_take    = w_idle && (w_gnt != 2'b00);
   assign w_rready  = (r_grant == GNT_DMMU) ? i_dmmu_rready : i_immu_rready;

   assign o_immu_arready = w_idle && w_gnt[0];
   assign o_dmmu_arready = w_idle && w_gnt[1];

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         r_state       <= IDLE;
         r_grant       <= GNT_IMMU;
         r_last_grant  <= GNT_IMMU;
         r_mem_arvalid <= 1'b0;
         r_busy        <= 1'b0;
         r_araddr      <= '0;
         r_arid        <= '0;
         r_arlen       <= '0;
         r_arsize      <= '0;
         r_arburst     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_take) begin
                  r_grant       <= w_gnt_idx;
                  r_last_grant  <= w_gnt_idx;
                  r_mem_arvalid <= 1'b1;
                  r_busy        <= 1'b1;
                  r_state       <= ADDR;
                  if (w_gnt_idx == GNT_DMMU) begin
                     r_araddr  <= i_dmmu_araddr;
                     r_arid    <= i_dmmu_arid;
                     r_arlen   <= i_dmmu_arlen;
                     r_arsize  <= i_dmmu_arsize;
                     r_arburst <= i_dmmu_arburst;
                  end else begin
                     r_araddr  <= i_immu_araddr;
                     r_arid    <= i_immu_arid;
                     r_arlen   <= i_immu_arlen;
                     r_arsize  <= i_immu_arsize;
                     r_arburst <= i_immu_arburst;
                  end
               end
            end
            ADDR: begin
               if (i_mem_arready) begin
                  r_mem_arvalid <= 1'b0;
                  r_state       <= DATA;
               end
            end
            DATA: begin
               // Only rlast closes the transaction; beat count is not tracked.
               if (i_mem_rvalid && w_rready && i_mem_rlast) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_mem_arvalid = r_mem_arvalid;
   assign o_mem_araddr  = r_araddr;
   assign o_mem_arid    = r_arid;
   assign o_mem_arlen   = r_arlen;
   assign o_mem_arsize  = r_arsize;
   assign o_mem_arburst = r_arburst;
   assign busy_o        = r_busy;

   assign o_mem_rready  = w_in_data && w_rready;
   assign o_immu_rvalid = w_in_data && (r_grant == GNT_IMMU) && i_mem_rvalid;
   assign o_dmmu_rvalid = w_in_data && (r_grant == GNT_DMMU) && i_mem_rvalid;

   // Payload is broadcast; only rvalid is steered by the grant.
   assign o_immu_rdata  = i_mem_rdata;
   assign o_immu_rresp  = i_mem_rresp;
   assign o_immu_rlast  = i_mem_rlast;
   assign o_immu_rid    = i_mem_rid;
   assign o_dmmu_rdata  = i_mem_rdata;
   assign o_dmmu_rresp  = i_mem_rresp;
   assign o_dmmu_rlast  = i_mem_rlast;
   assign o_dmmu_rid    = i_mem_rid;

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// Bench for ptw_axi_arbiter: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of who owns the downstream channel.
module tb_ptw_axi_arbiter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 4;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   logic          im_arvalid, im_arready, im_rvalid, im_rready, im_rlast;
   logic [AW-1:0] im_araddr;
   logic [IW-1:0] im_arid, im_rid;
   logic [7:0]    im_arlen;
   logic [2:0]    im_arsize;
   logic [1:0]    im_arburst, im_rresp;
   logic [DW-1:0] im_rdata;

   logic          dm_arvalid, dm_arready, dm_rvalid, dm_rready, dm_rlast;
   logic [AW-1:0] dm_araddr;
   logic [IW-1:0] dm_arid, dm_rid;
   logic [7:0]    dm_arlen;
   logic [2:0]    dm_arsize;
   logic [1:0]    dm_arburst, dm_rresp;
   logic [DW-1:0] dm_rdata;

   logic          mem_arvalid, mem_arready, mem_rvalid, mem_rready, mem_rlast;
   logic [AW-1:0] mem_araddr;
   logic [IW-1:0] mem_arid, mem_rid;
   logic [7:0]    mem_arlen;
   logic [2:0]    mem_arsize;
   logic [1:0]    mem_arburst, mem_rresp;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   ptw_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
      .clk_i(clk), .arst_i(arst),
      .i_immu_arvalid(im_arvalid), .o_immu_arready(im_arready), .i_immu_araddr(im_araddr),
      .i_immu_arid(im_arid), .i_immu_arlen(im_arlen), .i_immu_arsize(im_arsize),
      .i_immu_arburst(im_arburst), .o_immu_rvalid(im_rvalid), .i_immu_rready(im_rready),
      .o_immu_rdata(im_rdata), .o_immu_rresp(im_rresp), .o_immu_rlast(im_rlast),
      .o_immu_rid(im_rid),
      .i_dmmu_arvalid(dm_arvalid), .o_dmmu_arready(dm_arready), .i_dmmu_araddr(dm_araddr),
      .i_dmmu_arid(dm_arid), .i_dmmu_arlen(dm_arlen), .i_dmmu_arsize(dm_arsize),
      .i_dmmu_arburst(dm_arburst), .o_dmmu_rvalid(dm_rvalid), .i_dmmu_rready(dm_rready),
      .o_dmmu_rdata(dm_rdata), .o_dmmu_rresp(dm_rresp), .o_dmmu_rlast(dm_rlast),
      .o_dmmu_rid(dm_rid),
      .o_mem_arvalid(mem_arvalid), .i_mem_arready(mem_arready), .o_mem_araddr(mem_araddr),
      .o_mem_arid(mem_arid), .o_mem_arlen(mem_arlen), .o_mem_arsize(mem_arsize),
      .o_mem_arburst(mem_arburst), .i_mem_rvalid(mem_rvalid), .o_mem_rready(mem_rready),
      .i_mem_rdata(mem_rdata), .i_mem_rresp(mem_rresp), .i_mem_rlast(mem_rlast),
      .i_mem_rid(mem_rid),
      .busy_o(busy)
   );

   // Model: is a transaction open, whose is it, has its AR been accepted downstream yet.
   bit            m_open, m_ar_wait, m_owner_d, m_last_d;
   logic [AW-1:0] m_addr;
   logic [IW-1:0] m_id;
   logic [7:0]    m_len;
   logic [2:0]    m_size;
   logic [1:0]    m_burst;

   int n_vec = 0;
   int n_err = 0;

   // Snapshots taken at the falling edge of the last step.
   logic          s_busy, s_im_arready, s_dm_arready, s_im_rvalid, s_dm_rvalid;
   logic          s_mem_arvalid, s_mem_rready;
   logic [DW-1:0] s_im_rdata;
   logic [AW-1:0] s_mem_araddr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      bit im_win, dm_win, exp_rr, beat_phase;
      @(negedge clk);
      s_busy = busy; s_im_arready = im_arready; s_dm_arready = dm_arready;
      s_im_rvalid = im_rvalid; s_dm_rvalid = dm_rvalid; s_mem_arvalid = mem_arvalid;
      s_mem_rready = mem_rready; s_im_rdata = im_rdata; s_mem_araddr = mem_araddr;

      // A lone requester wins; on a tie the walker that did not win last time wins.
      im_win = !arst && !m_open && im_arvalid && (!dm_arvalid || m_last_d);
      dm_win = !arst && !m_open && dm_arvalid && (!im_arvalid || !m_last_d);
      beat_phase = !arst && m_open && !m_ar_wait;
      exp_rr = beat_phase && (m_owner_d ? dm_rready : im_rready);

      chk("immu_arready", im_arready, im_win);
      chk("dmmu_arready", dm_arready, dm_win);
      chk("busy", busy, m_open);
      chk("mem_arvalid", mem_arvalid, m_open && m_ar_wait);
      if (m_open && m_ar_wait) begin
         chk("mem_araddr", mem_araddr, m_addr);
         chk("mem_ar_attr", {mem_arid, mem_arlen, mem_arsize, mem_arburst},
             {m_id, m_len, m_size, m_burst});
      end
      chk("mem_rready", mem_rready, exp_rr);
      chk("immu_rvalid", im_rvalid, beat_phase && !m_owner_d && mem_rvalid);
      chk("dmmu_rvalid", dm_rvalid, beat_phase && m_owner_d && mem_rvalid);
      if (beat_phase && mem_rvalid) begin
         if (m_owner_d) chk("dmmu_rpayload", {dm_rdata, dm_rresp, dm_rlast, dm_rid},
                            {mem_rdata, mem_rresp, mem_rlast, mem_rid});
         else           chk("immu_rpayload", {im_rdata, im_rresp, im_rlast, im_rid},
                            {mem_rdata, mem_rresp, mem_rlast, mem_rid});
      end

      if (arst) begin
         m_open = 0; m_ar_wait = 0; m_owner_d = 0; m_last_d = 0;
      end else if (!m_open) begin
         if (im_win || dm_win) begin
            m_open = 1; m_ar_wait = 1; m_owner_d = dm_win; m_last_d = dm_win;
            m_addr  = dm_win ? dm_araddr  : im_araddr;
            m_id    = dm_win ? dm_arid    : im_arid;
            m_len   = dm_win ? dm_arlen   : im_arlen;
            m_size  = dm_win ? dm_arsize  : im_arsize;
            m_burst = dm_win ? dm_arburst : im_arburst;
         end
      end else if (m_ar_wait) begin
         if (mem_arready) m_ar_wait = 0;
      end else if (mem_rvalid && exp_rr && mem_rlast) begin
         m_open = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      im_arvalid = 0; dm_arvalid = 0; im_rready = 0; dm_rready = 0;
      mem_arready = 0; mem_rvalid = 0; mem_rlast = 0;
   endtask

   task automatic req(input bit d, input logic [63:0] addr, input logic [7:0] len);
      if (d) begin
         dm_arvalid = 1; dm_araddr = addr; dm_arlen = len; dm_arid = 4'h5;
         dm_arsize = 3'd3; dm_arburst = 2'd1;
      end else begin
         im_arvalid = 1; im_araddr = addr; im_arlen = len; im_arid = 4'h3;
         im_arsize = 3'd3; im_arburst = 2'd1;
      end
   endtask

   task automatic drain();
      int k;
      quiet();
      mem_arready = 1; mem_rvalid = 1; mem_rlast = 1; im_rready = 1; dm_rready = 1;
      k = 0;
      while (m_open && k < 50) begin step(); k++; end
      chk("drain_done", m_open, 0);
      quiet();
      step();
   endtask

   initial begin
      int busy_cnt, beats, cyc;
      bit gnt_q[$];
      bit acc;
      arst = 1;
      quiet();
      im_araddr = '0; im_arid = '0; im_arlen = '0; im_arsize = '0; im_arburst = '0;
      dm_araddr = '0; dm_arid = '0; dm_arlen = '0; dm_arsize = '0; dm_arburst = '0;
      mem_rdata = '0; mem_rresp = '0; mem_rid = '0;
      step();
      chk("reset_busy", s_busy, 0);
      chk("reset_mem_arvalid", s_mem_arvalid, 0);
      arst = 0;
      step();

      // Single immu request, response one cycle after entering DATA.
      req(0, 64'h8000_1000, 8'd0);
      mem_arready = 1;
      busy_cnt = 0;
      step();
      busy_cnt += int'(s_busy);
      chk("t1_immu_granted", s_im_arready, 1);
      im_arvalid = 0;
      step();
      busy_cnt += int'(s_busy);
      chk("t1_mem_araddr", s_mem_araddr, 64'h8000_1000);
      step();
      busy_cnt += int'(s_busy);
      mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF; mem_rlast = 1; mem_rresp = 2'd0;
      mem_rid = 4'h3; im_rready = 1;
      step();
      busy_cnt += int'(s_busy);
      chk("t1_immu_rvalid", s_im_rvalid, 1);
      chk("t1_immu_rdata", s_im_rdata, 64'hDEAD_BEEF);
      chk("t1_dmmu_rvalid", s_dm_rvalid, 0);
      quiet();
      step();
      busy_cnt += int'(s_busy);
      chk("t1_busy_cycles", busy_cnt, 3);

      // Simultaneous requests from reset alternate dmmu, immu, dmmu.
      arst = 1; step(); arst = 0;
      req(0, 64'h1000, 8'd0); req(1, 64'h2000, 8'd0);
      mem_arready = 1; mem_rvalid = 1; mem_rlast = 1; im_rready = 1; dm_rready = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (s_im_arready) gnt_q.push_back(1'b0);
         if (s_dm_arready) gnt_q.push_back(1'b1);
      end
      chk("t2_grant_count", gnt_q.size(), 3);
      if (gnt_q.size() >= 3) begin
         chk("t2_first_dmmu", gnt_q[0], 1);
         chk("t2_second_immu", gnt_q[1], 0);
         chk("t2_third_dmmu", gnt_q[2], 1);
      end
      drain();

      // Downstream AR stall with both walkers knocking.
      req(1, 64'hCAFE_0040, 8'd0);
      step();
      req(0, 64'h1111_0000, 8'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_arvalid_held", s_mem_arvalid, 1);
         chk("t3_araddr_stable", s_mem_araddr, 64'hCAFE_0040);
         chk("t3_no_walker_ready", {s_im_arready, s_dm_arready}, 2'b00);
      end
      drain();

      // Four-beat burst with immu rready toggling.
      req(0, 64'h4000_0000, 8'd3);
      mem_arready = 1;
      step();
      im_arvalid = 0;
      step();
      beats = 0; cyc = 0;
      mem_rvalid = 1;
      while (beats < 4 && cyc < 20) begin
         mem_rdata = 64'h100 + 64'(beats);
         mem_rlast = (beats == 3);
         im_rready = cyc[0];
         step();
         chk("t4_rready_mirror", s_mem_rready, im_rready);
         acc = s_im_rvalid && im_rready;
         if (acc) begin
            chk("t4_beat_order", s_im_rdata, 64'h100 + 64'(beats));
            beats++;
            if (beats < 4) chk("t4_busy_mid", s_busy, 1);
         end
         cyc++;
      end
      chk("t4_beats", beats, 4);
      quiet();
      step();
      chk("t4_idle_after", s_busy, 0);

      // Reset while in DATA.
      req(0, 64'h5000, 8'd0);
      mem_arready = 1;
      step();
      im_arvalid = 0;
      step();
      step();
      req(0, 64'h5100, 8'd0); req(1, 64'h5200, 8'd0);
      arst = 1;
      step();
      arst = 0;
      quiet();
      step();
      chk("t5_busy", s_busy, 0);
      chk("t5_valids", {s_mem_arvalid, s_mem_rready, s_im_arready, s_dm_arready}, 4'b0);
      req(0, 64'h5100, 8'd0); req(1, 64'h5200, 8'd0);
      step();
      chk("t5_tie_dmmu", {s_dm_arready, s_im_arready}, 2'b10);
      drain();

      // Stray beat while idle.
      mem_rvalid = 1; mem_rlast = 1; im_rready = 1; dm_rready = 1;
      step();
      chk("t6_mem_rready", s_mem_rready, 0);
      chk("t6_no_rvalid", {s_im_rvalid, s_dm_rvalid}, 2'b00);
      quiet();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         arst = ($urandom_range(0, 199) == 0);
         im_arvalid = ($urandom_range(0, 2) == 0);
         dm_arvalid = ($urandom_range(0, 2) == 0);
         im_araddr = {$urandom, $urandom}; dm_araddr = {$urandom, $urandom};
         im_arid = 4'($urandom); dm_arid = 4'($urandom);
         im_arlen = 8'($urandom); dm_arlen = 8'($urandom);
         im_arsize = 3'($urandom); dm_arsize = 3'($urandom);
         im_arburst = 2'($urandom); dm_arburst = 2'($urandom);
         im_rready = $urandom_range(0, 1); dm_rready = $urandom_range(0, 1);
         mem_arready = $urandom_range(0, 1);
         mem_rvalid = $urandom_range(0, 1);
         mem_rlast = ($urandom_range(0, 2) == 0);
         mem_rdata = {$urandom, $urandom};
         mem_rresp = 2'($urandom); mem_rid = 4'($urandom);
         step();
      end
      arst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ptw_axi_arbiter.md
# ptw_axi_arbiter

Shares one downstream AXI read channel (AR + R) between the instruction-side and data-side MMU page-table walkers of the prv664 pipeline. At most one read transaction is outstanding at a time. The block grants one walker, holds that grant until the final read beat, and routes the response back to the granted walker. It sits between the pipeline's `immu_axi_ar/r` and `dmmu_axi_ar/r` ports and the system bus or L2 read port.

## Interface
Parameters:
- `ADDR_W`, 64: `araddr` width.
- `DATA_W`, 64: `rdata` width.
- `ID_W`, 4: `arid`/`rid` width; carried through unchanged.

Ports:
- `clk_i`  in  1  clock; all logic is posedge.
- `arst_i`  in  1  reset, synchronous, active-high.
- `immu_axi_ar`  slave  axi_ar  I-walker address request (`arvalid`, `arready`, `araddr`, `arid`, `arlen`, `arsize`, `arburst`).
- `immu_axi_r`  slave  axi_r  I-walker read data (`rvalid`, `rready`, `rdata`, `rresp`, `rlast`, `rid`).
- `dmmu_axi_ar`  slave  axi_ar  D-walker address request.
- `dmmu_axi_r`  slave  axi_r  D-walker read data.
- `mem_axi_ar`  master  axi_ar  downstream address request.
- `mem_axi_r`  master  axi_r  downstream read data.
- `busy_o`  out  1  high whenever state ≠ IDLE.

## Operation
State machine:
- **IDLE**
  - If any walker has `arvalid`, arbitrate.
  - Drive `arready=1` to the winner only, in the same cycle (combinational).
  - Latch the winner's AR fields into the request register.
  - Set `grant` (0 = immu, 1 = dmmu) and go to ADDR.
- **ADDR**
  - `mem.arvalid=1` with the registered fields.
  - On `mem.arready` go to DATA.
  - Fields stay stable until the handshake.
- **DATA**
  - Forward `mem.rvalid/rdata/rresp/rlast/rid` to the granted walker.
  - `mem.rready` = granted walker's `rready`.
  - Non-granted walker sees `rvalid=0`.
  - On `rvalid & rready & rlast` go to IDLE.

Arbitration rules:
- Round-robin using register `last_grant`, updated when a grant is taken.
- If both walkers request, grant goes to the walker ≠ `last_grant`.
- If one walker requests, it wins regardless of `last_grant`.
- Reset value `last_grant=0` (immu), so dmmu wins the first tie.

Other rules:
- Walkers' `arready` is 0 in ADDR and DATA; new requests wait.
- `mem.rready=0` outside DATA; stray beats are never accepted.
- Response routing is by `grant`, not by `rid`. `rid` and `rresp` pass through untouched; error responses are forwarded like data.
- Beat count is not checked; only `rlast` ends the transaction.

Reset (`arst_i` high at a posedge):
- State returns to IDLE, `grant=0`, `last_grant=0`, and the request register is cleared.
- All valid/ready outputs are 0 and `busy_o=0`.
- Reset mid-transaction abandons the transaction. Downstream is reset by the same reset.

## Timing
- AR latency: walker `arvalid` in cycle N, `arready` in cycle N (if IDLE), `mem.arvalid` in cycle N+1.
- Minimum single-beat turnaround, from walker AR accept to IDLE:
  - 3 cycles: N accept, N+1 AR handshake, N+2 R beat with `rlast`, back in IDLE at N+3.
  - The next grant can be given at N+3.
- R path is combinational (zero added latency) in DATA.
- A request asserted in the same cycle that `rlast` completes is granted the following cycle; no same-cycle IDLE bypass.
- Backpressure:
  - `mem.arready` low holds ADDR indefinitely.
  - Walker `rready` low stalls `mem.rready`.

## Structure
- Shared package holds:
  - `ptw_arb_state_e` (IDLE, ADDR, DATA).
  - Grant encodings `GNT_IMMU=1'b0` and `GNT_DMMU=1'b1`.
- Sub-module `rr_arb2`:
  - Inputs: two requests, `last_grant`.
  - Outputs: one-hot grant, grant index.
  - Combinational; reused by the store-buffer and cache-refill arbiters.
- The top holds the FSM, the request register and the R-path mux; roughly 200 RTL lines.

## Test plan
- **Single immu request.** Immu AR `addr=0x8000_1000`, `arlen=0`; memory returns `rdata=0xDEAD_BEEF`, `rlast=1`.
  - Immu `rvalid` with that data; dmmu `rvalid` stays 0.
  - `busy_o` high for exactly 3 cycles.
- **Simultaneous requests from reset.** Both walkers assert `arvalid` from reset.
  - Dmmu is granted first; immu is granted second after dmmu's `rlast`.
  - A repeated simultaneous pair alternates again.
- **Downstream AR stall.** Hold `mem.arready=0` for 5 cycles.
  - `mem.arvalid` stays high with a stable address.
  - Both walkers' `arready` stay 0 until the transaction completes.
- **Multi-beat burst with walker backpressure.** Burst `arlen=3`; granted walker `rready` toggles.
  - `mem.rready` mirrors it; all 4 beats delivered in order.
  - IDLE only after beat 4 with `rlast`.
- **Reset mid-operation.** Assert `arst_i` during DATA.
  - Next cycle: state IDLE, all valids/readies 0, `last_grant=0`.
  - Post-reset tie grants dmmu.
- **Stray response beat.** `mem.rvalid=1` while IDLE.
  - `mem.rready=0`; neither walker sees `rvalid`.
